// File: rtl/arb_pkg.sv
// Shared types, sizes and the rotating first-set search for the 8-way arbiter.
package arb_pkg;

  localparam int NREQ = 8;
  localparam int IDW  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Result of a round-robin search: whether any request was set, and which one.
  typedef struct packed {
    logic           found;
    logic [IDW-1:0] idx;
  } rr_pick_t;

  // Returns the first set bit of req, scanning ptr, ptr+1, ... modulo NREQ.
  // The 3-bit candidate index wraps naturally, so no explicit modulo is needed.
  function automatic rr_pick_t rr_first_set(input logic [NREQ-1:0] req,
                                            input logic [IDW-1:0]  ptr);
    rr_pick_t       pick;
    logic [IDW-1:0] cand;
    pick.found = 1'b0;
    pick.idx   = '0;
    cand       = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = ptr + IDW'(i);
      if (!pick.found && req[cand]) begin
        pick.found = 1'b1;
        pick.idx   = cand;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/onehot_dec_3_8.sv
// Combinational 3-bit index to 8-bit one-hot decoder.
module onehot_dec_3_8
  import arb_pkg::*;
(
  input  logic [IDW-1:0]  i_idx,
  output logic [NREQ-1:0] o_onehot
);

  // One comparator per output bit; exactly one bit is ever high.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_dec
    assign o_onehot[gi] = (i_idx == IDW'(gi));
  end

endmodule

// File: rtl/arb_rr_8.sv
// Round-robin arbiter for eight requesters with a one-hot grant, a mandatory
// dead cycle between owners and a hold limit that force-releases a grant.
// MAX_HOLD must lie in 2..255 and 2**CW must exceed MAX_HOLD.
module arb_rr_8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CW       = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_valid,
  output logic            timeout
);

  state_t          r_state;
  logic [IDW-1:0]  r_ptr;
  logic [CW-1:0]   r_cnt;
  logic [NREQ-1:0] r_gnt;
  logic [IDW-1:0]  r_gnt_id;
  logic            r_gnt_valid;
  logic            r_timeout;

  state_t          w_state_next;
  rr_pick_t        w_pick;
  logic [NREQ-1:0] w_dec;
  logic            w_release;
  logic            w_timeout_next;
  logic            w_at_limit;

  // Next winner from the current pointer; only consumed while IDLE.
  assign w_pick = rr_first_set(req, r_ptr);

  onehot_dec_3_8 u_dec (
    .i_idx   (w_pick.idx),
    .o_onehot(w_dec)
  );

  assign w_at_limit = (r_cnt == CW'(MAX_HOLD - 1));

  // Next-state and release decision; done/abandon take precedence over the
  // hold limit so a coinciding done never reports a timeout.
  always_comb begin
    w_state_next   = r_state;
    w_release      = 1'b0;
    w_timeout_next = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick.found) begin
          w_state_next = GRANT;
        end
      end
      GRANT: begin
        if (done || !req[r_gnt_id]) begin
          w_release    = 1'b1;
          w_state_next = IDLE;
        end else if (w_at_limit) begin
          w_release      = 1'b1;
          w_timeout_next = 1'b1;
          w_state_next   = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State, pointer, hold counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_timeout <= w_timeout_next;
      case (r_state)
        IDLE: begin
          if (w_pick.found) begin
            r_gnt       <= w_dec;
            r_gnt_id    <= w_pick.idx;
            r_gnt_valid <= 1'b1;
            r_cnt       <= '0;
            r_ptr       <= w_pick.idx + IDW'(1);
          end
        end
        GRANT: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_release) begin
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
          end
        end
        default: begin
          r_gnt       <= '0;
          r_gnt_id    <= '0;
          r_gnt_valid <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_arb_rr_8.sv
// Directed-vector bench for arb_rr_8: a per-cycle table plus hand sequences
// for the hold limit, done at the limit and asynchronous reset mid-grant.
module tb_arb_rr_8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int n_vec;
  int n_err;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       valid;
    logic       to;
    string      name;
  } vec_t;

  vec_t tbl[$];

  arb_rr_8 #(.MAX_HOLD(16), .CW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input logic [7:0] eg, input logic [2:0] ei, input logic ev,
                       input logic et, input string nm);
    n_vec++;
    if (gnt !== eg || gnt_id !== ei || gnt_valid !== ev || timeout !== et) begin
      n_err++;
      $display("FAIL %s: got gnt=%h id=%0d valid=%b timeout=%b, expected gnt=%h id=%0d valid=%b timeout=%b",
               nm, gnt, gnt_id, gnt_valid, timeout, eg, ei, ev, et);
    end else begin
      $display("ok   %s: gnt=%h id=%0d valid=%b timeout=%b", nm, gnt, gnt_id, gnt_valid, timeout);
    end
  endtask

  // Drive inputs on the falling edge, sample 1 ns after the rising edge.
  task automatic step(input logic r, input logic [7:0] rq, input logic d,
                      input logic [7:0] eg, input logic [2:0] ei, input logic ev,
                      input logic et, input string nm);
    @(negedge clk);
    rst  = r;
    req  = rq;
    done = d;
    @(posedge clk);
    #1;
    check(eg, ei, ev, et, nm);
  endtask

  task automatic add(input logic r, input logic [7:0] rq, input logic d,
                     input logic [7:0] eg, input logic [2:0] ei, input logic ev,
                     input logic et, input string nm);
    vec_t v;
    v.rst = r; v.req = rq; v.done = d; v.gnt = eg; v.id = ei;
    v.valid = ev; v.to = et; v.name = nm;
    tbl.push_back(v);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    req   = 8'h00;
    done  = 1'b0;

    // ---------------- table ----------------
    // Reset, single requester 2, done release (ptr becomes 3).
    add(1, 8'h00, 0, 8'h00, 3'd0, 0, 0, "reset_hold");
    add(0, 8'h04, 0, 8'h04, 3'd2, 1, 0, "single_grant2");
    add(0, 8'h04, 1, 8'h00, 3'd0, 0, 0, "single_done");
    add(0, 8'h00, 0, 8'h00, 3'd0, 0, 0, "idle_after_done");
    // Fresh reset so rotation starts at port 0.
    add(1, 8'h00, 0, 8'h00, 3'd0, 0, 0, "rot_reset");
    add(0, 8'h00, 0, 8'h00, 3'd0, 0, 0, "rot_idle");
    for (int k = 0; k < 8; k++) begin
      add(0, 8'hFF, 0, 8'(1 << k), 3'(k), 1, 0, $sformatf("rot_grant%0d", k));
      add(0, 8'hFF, 1, 8'h00, 3'd0, 0, 0, $sformatf("rot_release%0d", k));
    end
    add(0, 8'hFF, 0, 8'h01, 3'd0, 1, 0, "rot_wrap_grant0");
    add(0, 8'hFF, 1, 8'h00, 3'd0, 0, 0, "rot_wrap_release");
    // ptr=1: grant 7, then 8'h81 must go to 0.
    add(0, 8'h80, 0, 8'h80, 3'd7, 1, 0, "wrap_grant7");
    add(0, 8'h80, 1, 8'h00, 3'd0, 0, 0, "wrap_release7");
    add(0, 8'h81, 0, 8'h01, 3'd0, 1, 0, "wrap_next_is0");
    add(0, 8'h81, 1, 8'h00, 3'd0, 0, 0, "wrap_release0");
    // ptr=1: abandon by dropping the owner's request.
    add(0, 8'h02, 0, 8'h02, 3'd1, 1, 0, "abandon_grant1");
    add(0, 8'h00, 0, 8'h00, 3'd0, 0, 0, "abandon_release");
    add(0, 8'h00, 1, 8'h00, 3'd0, 0, 0, "done_in_idle");
    // ptr=2: new requests during grant are ignored.
    add(0, 8'h08, 0, 8'h08, 3'd3, 1, 0, "hold_grant3");
    add(0, 8'h0F, 0, 8'h08, 3'd3, 1, 0, "hold_ignore_new");
    add(0, 8'h0F, 1, 8'h00, 3'd0, 0, 0, "hold_release3");
    // ptr=4: 8'h0F wraps the search around to 0.
    add(0, 8'h0F, 0, 8'h01, 3'd0, 1, 0, "search_wrap_grant0");
    add(0, 8'h00, 1, 8'h00, 3'd0, 0, 0, "done_plus_abandon");
    add(0, 8'h00, 0, 8'h00, 3'd0, 0, 0, "idle_quiet");

    // Reset state check before any clock edge with rst released.
    #3;
    check(8'h00, 3'd0, 1'b0, 1'b0, "reset_state");

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].done, tbl[i].gnt, tbl[i].id,
           tbl[i].valid, tbl[i].to, tbl[i].name);
    end

    // ---------------- hold limit ----------------
    step(1, 8'h00, 0, 8'h00, 3'd0, 0, 0, "to_reset");
    step(0, 8'h10, 0, 8'h10, 3'd4, 1, 0, "to_grant_c0");
    for (int c = 1; c < 16; c++) begin
      step(0, 8'h10, 0, 8'h10, 3'd4, 1, 0, $sformatf("to_hold_c%0d", c));
    end
    step(0, 8'h10, 0, 8'h00, 3'd0, 0, 1, "to_release_pulse");
    step(0, 8'h10, 0, 8'h10, 3'd4, 1, 0, "to_regrant4");

    // ---------------- done on hold cycle 15 ----------------
    for (int c = 1; c < 16; c++) begin
      step(0, 8'h10, 0, 8'h10, 3'd4, 1, 0, $sformatf("dl_hold_c%0d", c));
    end
    step(0, 8'h10, 1, 8'h00, 3'd0, 0, 0, "dl_done_at_limit");
    step(0, 8'h00, 0, 8'h00, 3'd0, 0, 0, "dl_idle");

    // ---------------- asynchronous reset mid-grant ----------------
    step(0, 8'h20, 0, 8'h20, 3'd5, 1, 0, "ar_grant5");
    #2;
    rst = 1'b1;
    #1;
    check(8'h00, 3'd0, 1'b0, 1'b0, "ar_async_clear");
    step(1, 8'hFF, 0, 8'h00, 3'd0, 0, 0, "ar_held");
    step(0, 8'hFF, 0, 8'h01, 3'd0, 1, 0, "ar_first_grant0");
    step(0, 8'hFF, 1, 8'h00, 3'd0, 0, 0, "ar_release");
    step(0, 8'hFF, 0, 8'h02, 3'd1, 1, 0, "ar_next_grant1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/arb_rr_8.md
# arb_rr_8

Round-robin arbiter that shares one 8-way one-hot select among eight requesters. It turns a 3-bit winner index into the one-hot grant vector that drives the shared resource. It holds each grant until the owner signals done, drops its request, or exceeds a hold limit. It sits between the requesting units and the one-hot-selected resource, such as a bus mux or a shared register bank.

## Interface
- `MAX_HOLD`, default 16. Maximum cycles a grant may stay in GRANT; legal range 2..255.
- `CW`, default 8. Width of the hold counter; must satisfy `2**CW > MAX_HOLD`.

Ports (one clock; reset is asynchronous and active-high):
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input 8: per-requester request level; bit k is requester k.
- `done` input 1: release pulse from the current owner; only meaningful while `gnt_valid`=1.
- `gnt` output 8: one-hot grant, all zero when idle.
- `gnt_id` output 3: index of the current owner; 0 when idle.
- `gnt_valid` output 1: a grant is active (`gnt` != 0).
- `timeout` output 1: one-cycle pulse when a grant is force-released by `MAX_HOLD`.

## Operation
- State machine has two states, IDLE and GRANT.
- Reset values: state=IDLE, `gnt`=8'h00, `gnt_id`=3'd0, `gnt_valid`=0, `timeout`=0, priority pointer `ptr`=3'd0, hold counter=0.
- **IDLE, `req`==0:** stay in IDLE.
- **IDLE, `req`!=0:**
  - Winner = first set bit searching `ptr`, `ptr`+1, … mod 8.
  - Register `gnt_id`=winner; `gnt` = one-hot decode of winner; `gnt_valid`=1; go to GRANT.
  - Clear the hold counter.
  - Set `ptr` = winner+1 mod 8, so 7 wraps to 0.
- **GRANT:** the hold counter increments every cycle. Release happens on the first of these:
  - (a) `done`=1;
  - (b) `req[gnt_id]`=0 (abandon);
  - (c) counter == `MAX_HOLD`-1 with neither (a) nor (b). This also asserts `timeout` for exactly the next cycle.
- **On release:** next cycle `gnt`=0, `gnt_id`=0, `gnt_valid`=0, state=IDLE.
  - This gives one mandatory dead cycle between owners, which guarantees no overlap of the one-hot select.
- **Simultaneous events:**
  - `done` together with the timeout condition counts as a normal release; `timeout` stays 0.
  - `done` together with `req[gnt_id]`=0 counts as a single release.
  - New requests arriving during GRANT are ignored until IDLE.
- `done` while IDLE is ignored.
- `gnt` is always either zero or exactly one bit, and always equals the decode of `gnt_id` when `gnt_valid`=1.
- **Reset mid-grant:** all outputs drop to their reset values asynchronously. `ptr` returns to 0, so fairness history is lost.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Request-to-grant latency: `req` sampled at edge N in IDLE gives `gnt` valid after edge N.
- Release latency: `done` sampled at edge M gives `gnt`=0 after edge M. The earliest next grant is after edge M+1.
- Maximum grant duration is `MAX_HOLD` cycles. `timeout` is high in the first cycle with `gnt`=0.
- Worst-case wait for a continuously requesting port: 7 × (`MAX_HOLD`+1) cycles.

## Structure
- Shared package `arb_pkg` holds:
  - the state enum (IDLE, GRANT);
  - `NREQ`=8 and `IDW`=3;
  - a function for the rotating first-set search.
- One sub-module: `onehot_dec_3_8`, a combinational 3-bit index to 8-bit one-hot decode. It feeds the `gnt` register.
- The rest is a single always_ff for state/ptr/counter/outputs plus combinational next-winner logic.

## Test plan
- **Reset and single requester.** Assert `rst`, release it, drive `req`=8'h04. Expected: next cycle `gnt`=8'h04, `gnt_id`=2, `gnt_valid`=1. Pulse `done`; the cycle after, `gnt`=0. `ptr` is now 3.
- **Round-robin rotation.** Hold `req`=8'hFF and pulse `done` on every grant. Expected grant order: 0,1,2,…,7,0, with one idle cycle between each.
- **Pointer wrap.** Grant 7, then `req`=8'h81. Expected: the next grant goes to port 0, not 7.
- **Timeout.** With `MAX_HOLD`=16, hold `req`=8'h10 and never assert `done`. Expected: `gnt` stays 8'h10 for exactly 16 cycles, then drops; `timeout`=1 for one cycle; a re-grant to port 4 follows after the dead cycle.
- **Abandon, and `done` coinciding with the limit.**
  - Drop `req[gnt_id]` mid-grant. Expected: release next cycle with `timeout`=0.
  - Assert `done` on hold cycle 15. Expected: `timeout` stays 0.
- **Asynchronous reset mid-grant.** While `gnt`=8'h20, assert `rst` between clock edges. Expected: `gnt`=0, `gnt_valid`=0 immediately. After release with `req`=8'hFF, the first grant is to port 0.
